// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator turning a 1-bit PDM stream into 16-bit PCM.
// Integrators run on every accepted PDM sample; every R samples a strobe
// launches one pass through the comb section and then the output stage.
//
// Output qualification: pcm_valid is a single-cycle pulse that marks a new
// pcm_out sample; there is no back-pressure, so the consumer must take the
// sample in the cycle pcm_valid is high. pcm_out holds between pulses.
module pdm_cic_decimator #(
    parameter int DEC_LOG2 = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pdm_en,
    input  logic               pdm_in,
    input  logic               clr,
    output logic signed [15:0] pcm_out,
    output logic               pcm_valid
);

    localparam int W  = 3 * DEC_LOG2 + 2;
    localparam int SH = 3 * DEC_LOG2 - 15;

    localparam logic signed [W-1:0] P_MAX = W'(32767);
    localparam logic signed [W-1:0] P_MIN = W'(-32768);

    // Integrator section and decimation counter
    logic [W-1:0]        r_i1;
    logic [W-1:0]        r_i2;
    logic [W-1:0]        r_i3;
    logic [DEC_LOG2-1:0] r_cnt;
    logic                r_strobe;

    // Comb section
    logic [W-1:0]        r_d1;
    logic [W-1:0]        r_d2;
    logic [W-1:0]        r_d3;
    logic [W-1:0]        r_c3;
    logic                r_c_new;
    logic                r_c_vld;
    logic [1:0]          r_warm;

    logic [W-1:0]        w_x;
    logic                w_cnt_last;
    logic [W-1:0]        w_c1;
    logic [W-1:0]        w_c2;
    logic [W-1:0]        w_c3;
    logic signed [W-1:0] w_shift;
    logic [15:0]         w_sat;

    // Map the PDM bit to +1/-1 and compute the comb differences
    always_comb begin
        w_x        = pdm_in ? W'(1) : {W{1'b1}};
        w_cnt_last = (r_cnt == {DEC_LOG2{1'b1}});
        w_c1       = r_i3 - r_d1;
        w_c2       = w_c1 - r_d2;
        w_c3       = w_c2 - r_d3;
    end

    // Shift the comb result down to 16 bits and clamp to the PCM range
    always_comb begin
        w_shift = $signed(r_c3) >>> SH;
        if (w_shift > P_MAX) begin
            w_sat = 16'h7fff;
        end else if (w_shift < P_MIN) begin
            w_sat = 16'h8000;
        end else begin
            w_sat = w_shift[15:0];
        end
    end

    // Integrators, decimation counter and strobe; clr discards the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i1     <= '0;
            r_i2     <= '0;
            r_i3     <= '0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (clr) begin
            r_i1     <= '0;
            r_i2     <= '0;
            r_i3     <= '0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= pdm_en && w_cnt_last;
            if (pdm_en) begin
                r_i1  <= r_i1 + w_x;
                r_i2  <= r_i2 + r_i1;
                r_i3  <= r_i3 + r_i2;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Comb section and warm-up tracking, advanced once per decimation event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1    <= '0;
            r_d2    <= '0;
            r_d3    <= '0;
            r_c3    <= '0;
            r_c_new <= 1'b0;
            r_c_vld <= 1'b0;
            r_warm  <= 2'd0;
        end else if (clr) begin
            r_d1    <= '0;
            r_d2    <= '0;
            r_d3    <= '0;
            r_c3    <= '0;
            r_c_new <= 1'b0;
            r_c_vld <= 1'b0;
            r_warm  <= 2'd0;
        end else begin
            r_c_new <= r_strobe;
            r_c_vld <= r_strobe && (r_warm == 2'd3);
            if (r_strobe) begin
                r_d1 <= r_i3;
                r_d2 <= w_c1;
                r_d3 <= w_c2;
                r_c3 <= w_c3;
                if (r_warm != 2'd3) begin
                    r_warm <= r_warm + 2'd1;
                end
            end
        end
    end

    // Output register: updates on every comb result, pulses valid after warm-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else if (clr) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= r_c_vld;
            if (r_c_new) begin
                pcm_out <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: random and patterned PDM input, expected PCM
// samples from an equivalent FIR (three cascaded length-R boxcars) applied
// to the recorded input history.
module tb_pdm_cic_decimator;

    localparam int DEC_LOG2 = 6;
    localparam int R        = 1 << DEC_LOG2;
    localparam int SH       = 3 * DEC_LOG2 - 15;
    localparam int HL       = 3 * R - 2;

    logic               clk    = 1'b0;
    logic               rst_n  = 1'b0;
    logic               pdm_en = 1'b0;
    logic               pdm_in = 1'b0;
    logic               clr    = 1'b0;
    logic signed [15:0] pcm_out;
    logic               pcm_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    int          hist[$];
    int          n_samp = 0;
    int          h[HL];

    logic signed [15:0] last_val   = '0;
    logic               prev_valid = 1'b0;
    int                 n_valid    = 0;
    logic [15:0]        m_e;
    int                 m_ec;

    pdm_cic_decimator #(.DEC_LOG2(DEC_LOG2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pdm_en   (pdm_en),
        .pdm_in   (pdm_in),
        .clr      (clr),
        .pcm_out  (pcm_out),
        .pcm_valid(pcm_valid)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected PCM sample once n input samples have been taken
    function automatic logic [15:0] model(input int n);
        int y;
        y = 0;
        for (int j = 0; j < HL; j++) y += h[j] * hist[n - 3 - j];
        y = y >>> SH;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y[15:0];
    endfunction

    // Apply one cycle of input and update the reference
    task automatic drive(input logic en, input logic din, input logic c);
        pdm_en = en;
        pdm_in = din;
        clr    = c;
        @(posedge clk);
        #1;
        if (c) begin
            while (exp_cyc_q.size() > 0 && exp_cyc_q[$] >= cyc) begin
                void'(exp_q.pop_back());
                void'(exp_cyc_q.pop_back());
            end
            hist.delete();
            n_samp = 0;
        end else if (en) begin
            hist.push_back(din ? 1 : -1);
            n_samp++;
            if ((n_samp % R) == 0 && (n_samp / R) >= 4) begin
                exp_q.push_back(model(n_samp));
                exp_cyc_q.push_back(cyc + 2);
            end
        end
    endtask

    task automatic run_rand(input int k);
        for (int i = 0; i < k; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        drive(1'b0, 1'b0, 1'b1);
        chk("clr_pcm_out_zero", pcm_out, 0);
        chk("clr_pcm_valid_zero", pcm_valid, 0);
        n_valid = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        pdm_en = 1'b0;
        clr    = 1'b0;
        #1;
        chk("rst_pcm_out_zero", pcm_out, 0);
        chk("rst_pcm_valid_zero", pcm_valid, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        hist.delete();
        n_samp  = 0;
        n_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pop and compare on every valid pulse
    always @(negedge clk) begin
        if (rst_n && pcm_valid) begin
            chk("valid_width", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got pcm_valid=1 with pcm_out=%0d, expected no pulse (cycle %0d)",
                         pcm_out, cyc);
            end else begin
                m_e  = exp_q.pop_front();
                m_ec = exp_cyc_q.pop_front();
                chk("pcm_out", pcm_out, int'($signed(m_e)));
                chk("valid_cycle", cyc, m_ec);
            end
            last_val = pcm_out;
            n_valid++;
        end
        prev_valid = pcm_valid;
    end

    initial begin
        int h2[2*R-1];
        for (int i = 0; i < 2*R-1; i++) h2[i] = 0;
        for (int i = 0; i < HL; i++) h[i] = 0;
        for (int a = 0; a < R; a++) for (int b = 0; b < R; b++) h2[a+b] += 1;
        for (int a = 0; a < 2*R-1; a++) for (int b = 0; b < R; b++) h[a+b] += h2[a];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pcm_out", pcm_out, 0);
        chk("reset_pcm_valid", pcm_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Constant +1, pdm_en every cycle
        n_valid = 0;
        for (int i = 0; i < 8*R; i++) drive(1'b1, 1'b1, 1'b0);
        idle(4);
        chk("const1_value", last_val, 32767);
        chk("const1_valid_count", n_valid, 5);

        // Constant -1
        do_clr();
        for (int i = 0; i < 8*R; i++) drive(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("const0_value", last_val, -32768);
        chk("const0_valid_count", n_valid, 5);

        // Alternating 1,0
        do_clr();
        for (int i = 0; i < 6*R; i++) drive(1'b1, 1'((i % 2) == 0), 1'b0);
        idle(4);
        chk("alt10_value", last_val, 0);
        chk("alt10_valid_count", n_valid, 3);

        // 1,1,1,0 repeating
        do_clr();
        for (int i = 0; i < 6*R; i++) drive(1'b1, 1'((i % 4) != 3), 1'b0);
        idle(4);
        chk("p1110_value", last_val, 16384);
        chk("p1110_valid_count", n_valid, 3);

        // pdm_en 1-in-4, constant +1
        do_clr();
        for (int i = 0; i < 4*6*R; i++) drive(1'((i % 4) == 0), 1'b1, 1'b0);
        idle(4);
        chk("sparse_value", last_val, 32767);
        chk("sparse_valid_count", n_valid, 3);

        // Random data and random pdm_en gaps
        do_clr();
        for (int i = 0; i < 1500; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
        idle(4);
        chk("random_queue_drained", exp_q.size(), 0);

        // clr on the strobe cycle, then at T+1 and at T+2 of pending events
        do_clr();
        run_rand(5*R - 1);
        drive(1'b1, 1'b1, 1'b1);
        chk("clr_strobe_pcm_out", pcm_out, 0);
        n_valid = 0;
        run_rand(4*R);
        drive(1'b1, 1'b1, 1'b1);
        run_rand(4*R);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        chk("clr_t2_pcm_valid", pcm_valid, 0);
        chk("clr_cancel_count", n_valid, 0);
        run_rand(5*R);
        idle(4);
        chk("clr_recover_count", n_valid, 2);

        // Asynchronous reset mid-block
        run_rand(4*R + R/2);
        pulse_reset();
        run_rand(3*R);
        idle(4);
        chk("rst_warmup_count", n_valid, 0);
        run_rand(2*R);
        idle(4);
        chk("rst_recover_count", n_valid, 2);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
